// File: rtl/dfr0520_pkg.sv
// -----------------------------------------------------------------------------
// dfr0520_pkg
// Shared definitions for the DFR0520 digital potentiometer SPI link. The
// transmitter and receiver both use these command encodings and the FSM type.
// -----------------------------------------------------------------------------
package dfr0520_pkg;

   // Command field encodings (frame bits [13:12]).
   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_SHDN  = 2'b10;

   // Receiver frame FSM.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_CHECK = 2'b10
   } state_t;

   // Meaningful fields of a received 16-bit frame.
   typedef struct packed {
      logic [1:0] cmd;
      logic [1:0] sel;
      logic [7:0] data;
   } frame_t;

   // Extract cmd/sel/data from the raw shift register contents.
   function automatic frame_t decode_frame(input logic [1:0] cmd_bits,
                                           input logic [1:0] sel_bits,
                                           input logic [7:0] data_bits);
      frame_t f;
      f.cmd  = cmd_bits;
      f.sel  = sel_bits;
      f.data = data_bits;
      return f;
   endfunction

endpackage

// File: rtl/dfr0520_sync_edge.sv
// -----------------------------------------------------------------------------
// dfr0520_sync_edge
// Multi-flop synchronizer for W asynchronous lanes, with rising/falling edge
// strobes on the most significant lane.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset; all lanes load RST_VAL
//   d_i     asynchronous inputs
//   sync_o  synchronized copies of d_i (STAGES cycles late)
//   rise_o  one-cycle strobe: lane W-1 went 0 -> 1
//   fall_o  one-cycle strobe: lane W-1 went 1 -> 0
// Extra lanes ride through the same chain so data stays aligned with the
// edge lane (MOSI travels alongside SCK).
// -----------------------------------------------------------------------------
module dfr0520_sync_edge #(
   parameter int           W       = 1,
   parameter int           STAGES  = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] sync_o,
   output logic         rise_o,
   output logic         fall_o
);

   logic [W-1:0] pipe_q [STAGES];
   logic         prev_q;

   // Synchronizer chain plus one history flop of the edge lane.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < STAGES; i++) begin
            pipe_q[i] <= RST_VAL;
         end
         prev_q <= RST_VAL[W-1];
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
         prev_q <= pipe_q[STAGES-1][W-1];
      end
   end

   assign sync_o = pipe_q[STAGES-1];
   assign rise_o = sync_o[W-1] & ~prev_q;
   assign fall_o = ~sync_o[W-1] & prev_q;

endmodule

// File: rtl/dfr0520_spi_rx.sv
// -----------------------------------------------------------------------------
// dfr0520_spi_rx
// SPI slave receiver for the DFR0520 dual digital potentiometer. Frames are
// 16 bits MSB first: [13:12] cmd, [9:8] sel, [7:0] data.
//   clk_in       system clock
//   rst_n        asynchronous active-low reset
//   CS/SCK/MOSI  SPI pins (asynchronous to clk_in, SCK <= clk_in/4)
//   wiper0/1     current wiper codes
//   shdn         per-channel shutdown flags (bit0 = channel 0)
//   cmd_out/sel_out/data_out  fields of the last valid frame
//   frame_valid  one-cycle pulse when a frame is accepted
//   frame_err    one-cycle pulse when a frame is discarded (wrong bit count)
// All outputs are registered.
// -----------------------------------------------------------------------------
module dfr0520_spi_rx
   import dfr0520_pkg::*;
#(
   parameter int         FRAME_BITS  = 16,
   parameter logic [7:0] RESET_WIPER = 8'h80,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       CS,
   input  logic       SCK,
   input  logic       MOSI,
   output logic [7:0] wiper0,
   output logic [7:0] wiper1,
   output logic [1:0] shdn,
   output logic [1:0] cmd_out,
   output logic [1:0] sel_out,
   output logic [7:0] data_out,
   output logic       frame_valid,
   output logic       frame_err
);

   localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

   logic       cs_sync_s, cs_rise_s, cs_fall_s;
   logic [1:0] sck_mosi_sync_s;
   logic       sck_rise_s, sck_fall_unused_s;
   logic       mosi_s;
   logic [3:0] dc_unused_s;
   frame_t     frame_s;

   state_t      state_q,  state_d;
   logic [15:0] shift_q,  shift_d;
   logic [4:0]  cnt_q,    cnt_d;
   logic [7:0]  wiper0_q, wiper0_d;
   logic [7:0]  wiper1_q, wiper1_d;
   logic [1:0]  shdn_q,   shdn_d;
   logic [1:0]  cmd_q,    cmd_d;
   logic [1:0]  sel_q,    sel_d;
   logic [7:0]  data_q,   data_d;
   logic        valid_q,  valid_d;
   logic        err_q,    err_d;

   // CS idles high, so its chain resets to 1 to avoid a false falling edge.
   dfr0520_sync_edge #(
      .W       (1),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync_cs (
      .clk_i  (clk_in),
      .rst_ni (rst_n),
      .d_i    (CS),
      .sync_o (cs_sync_s),
      .rise_o (cs_rise_s),
      .fall_o (cs_fall_s)
   );

   // MOSI shares the SCK chain so the sampled bit lines up with the SCK edge.
   dfr0520_sync_edge #(
      .W       (2),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (2'b00)
   ) u_sync_sck (
      .clk_i  (clk_in),
      .rst_ni (rst_n),
      .d_i    ({SCK, MOSI}),
      .sync_o (sck_mosi_sync_s),
      .rise_o (sck_rise_s),
      .fall_o (sck_fall_unused_s)
   );

   assign mosi_s      = sck_mosi_sync_s[0];
   assign dc_unused_s = {shift_q[15:14], shift_q[11:10]};
   assign frame_s     = decode_frame(shift_q[13:12], shift_q[9:8], shift_q[7:0]);

   // Next-state logic: frame capture, length check and channel updates.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      wiper0_d = wiper0_q;
      wiper1_d = wiper1_q;
      shdn_d   = shdn_q;
      cmd_d    = cmd_q;
      sel_d    = sel_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall_s) begin
               state_d = ST_SHIFT;
               shift_d = 16'h0000;
               cnt_d   = 5'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            if (cs_rise_s) begin
               state_d = ST_CHECK;
            end else if (sck_rise_s && !cs_sync_s) begin
               shift_d = {shift_q[14:0], mosi_s};
               // Saturate so overlong frames can never wrap back to a valid count.
               if (cnt_q != 5'd31) begin
                  cnt_d = cnt_q + 5'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end

         ST_CHECK: begin
            state_d = ST_IDLE;
            if (cnt_q == FRAME_CNT) begin
               valid_d = 1'b1;
               cmd_d   = frame_s.cmd;
               sel_d   = frame_s.sel;
               data_d  = frame_s.data;
               case (frame_s.cmd)
                  CMD_WRITE: begin
                     if (frame_s.sel[0]) begin
                        wiper0_d  = frame_s.data;
                        shdn_d[0] = 1'b0;
                     end else begin
                        wiper0_d  = wiper0_q;
                     end
                     if (frame_s.sel[1]) begin
                        wiper1_d  = frame_s.data;
                        shdn_d[1] = 1'b0;
                     end else begin
                        wiper1_d  = wiper1_q;
                     end
                  end
                  CMD_SHDN: begin
                     shdn_d = shdn_q | frame_s.sel;
                  end
                  CMD_NOP: begin
                     shdn_d = shdn_q;
                  end
                  default: begin
                     shdn_d = shdn_q;
                  end
               endcase
            end else begin
               err_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         shift_q  <= 16'h0000;
         cnt_q    <= 5'd0;
         wiper0_q <= RESET_WIPER;
         wiper1_q <= RESET_WIPER;
         shdn_q   <= 2'b00;
         cmd_q    <= 2'b00;
         sel_q    <= 2'b00;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         wiper0_q <= wiper0_d;
         wiper1_q <= wiper1_d;
         shdn_q   <= shdn_d;
         cmd_q    <= cmd_d;
         sel_q    <= sel_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign wiper0      = wiper0_q;
   assign wiper1      = wiper1_q;
   assign shdn        = shdn_q;
   assign cmd_out     = cmd_q;
   assign sel_out     = sel_q;
   assign data_out    = data_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;

endmodule

// File: tb/tb_dfr0520_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_dfr0520_spi_rx
// Directed bench for dfr0520_spi_rx. Each frame's expected outcome is pushed
// to a scoreboard when it is sent; a monitor pops and compares on every
// frame_valid / frame_err pulse.
// -----------------------------------------------------------------------------
module tb_dfr0520_spi_rx;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       CS, SCK, MOSI;
   logic [7:0] wiper0, wiper1, data_out;
   logic [1:0] shdn, cmd_out, sel_out;
   logic       frame_valid, frame_err;

   always #5 clk_in = ~clk_in;

   dfr0520_spi_rx dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .CS          (CS),
      .SCK         (SCK),
      .MOSI        (MOSI),
      .wiper0      (wiper0),
      .wiper1      (wiper1),
      .shdn        (shdn),
      .cmd_out     (cmd_out),
      .sel_out     (sel_out),
      .data_out    (data_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   typedef struct {
      bit         ok;
      logic [1:0] cmd;
      logic [1:0] sel;
      logic [7:0] data;
      logic [7:0] w0;
      logic [7:0] w1;
      logic [1:0] shdn;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state.
   logic [7:0] m_w0   = 8'h80;
   logic [7:0] m_w1   = 8'h80;
   logic [1:0] m_shdn = 2'b00;
   logic [1:0] m_cmd  = 2'b00;
   logic [1:0] m_sel  = 2'b00;
   logic [7:0] m_data = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [1:0] cmd, input logic [1:0] sel,
                                      input logic [7:0] data);
      return {16'h0000, 2'b00, cmd, 2'b00, sel, data};
   endfunction

   // Update the model for a frame of n bits and queue the expected outcome.
   task automatic expect_frame(input logic [31:0] word, input int n);
      exp_t e;
      logic [1:0] c, s;
      logic [7:0] d;
      c = word[13:12];
      s = word[9:8];
      d = word[7:0];
      e.ok = (n == 16);
      if (e.ok) begin
         m_cmd = c; m_sel = s; m_data = d;
         if (c == 2'b01) begin
            if (s[0]) begin m_w0 = d; m_shdn[0] = 1'b0; end
            if (s[1]) begin m_w1 = d; m_shdn[1] = 1'b0; end
         end else if (c == 2'b10) begin
            m_shdn = m_shdn | s;
         end
      end
      e.cmd = m_cmd; e.sel = m_sel; e.data = m_data;
      e.w0 = m_w0; e.w1 = m_w1; e.shdn = m_shdn;
      sb.push_back(e);
   endtask

   // Drive one SPI frame of n bits (MSB first), SCK = clk_in/4; CS then held
   // high for 'hold' cycles. Called and returns at a falling clk edge.
   task automatic send_frame(input logic [31:0] word, input int n, input int hold);
      CS = 1'b0;
      repeat (2) @(negedge clk_in);
      for (int i = n - 1; i >= 0; i--) begin
         SCK  = 1'b0;
         MOSI = word[i];
         repeat (2) @(negedge clk_in);
         SCK = 1'b1;
         repeat (2) @(negedge clk_in);
      end
      SCK = 1'b0;
      repeat (2) @(negedge clk_in);
      CS = 1'b1;
      repeat (hold) @(negedge clk_in);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_w0"},   wiper0,      8'h80);
      check({tag, "_w1"},   wiper1,      8'h80);
      check({tag, "_shdn"}, shdn,        2'b00);
      check({tag, "_cmd"},  cmd_out,     2'b00);
      check({tag, "_sel"},  sel_out,     2'b00);
      check({tag, "_data"}, data_out,    8'h00);
      check({tag, "_fv"},   frame_valid, 1'b0);
      check({tag, "_fe"},   frame_err,   1'b0);
   endtask

   // Scoreboard monitor: every pulse must match the oldest queued frame.
   always @(negedge clk_in) begin
      if (rst_n === 1'b1 && (frame_valid === 1'b1 || frame_err === 1'b1)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_kind", {30'd0, frame_valid, frame_err}, e.ok ? 32'd2 : 32'd1);
            check("wiper0",   wiper0,   e.w0);
            check("wiper1",   wiper1,   e.w1);
            check("shdn",     shdn,     e.shdn);
            check("cmd_out",  cmd_out,  e.cmd);
            check("sel_out",  sel_out,  e.sel);
            check("data_out", data_out, e.data);
         end
      end
   end

   initial begin
      int lat;
      rst_n = 1'b0; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
      repeat (3) @(negedge clk_in);
      check_reset_state("in_reset");
      rst_n = 1'b1;
      repeat (6) @(negedge clk_in);
      check_reset_state("after_reset");

      // Write channel 0, and measure pin-to-pulse latency.
      expect_frame(mk(2'b01, 2'b01, 8'hA5), 16);
      send_frame(mk(2'b01, 2'b01, 8'hA5), 16, 0);
      lat = 0;
      while (lat < 20 && frame_valid !== 1'b1) begin
         @(negedge clk_in);
         lat++;
      end
      check("latency", lat, 32'd4);
      repeat (6) @(negedge clk_in);
      check("w1_untouched", wiper1, 8'h80);

      // Shutdown both, then write channel 1 (clears only its shutdown).
      expect_frame(mk(2'b10, 2'b11, 8'h00), 16);
      send_frame(mk(2'b10, 2'b11, 8'h00), 16, 8);
      expect_frame(mk(2'b01, 2'b10, 8'hFF), 16);
      send_frame(mk(2'b01, 2'b10, 8'hFF), 16, 8);

      // Short, long and empty frames are discarded.
      expect_frame(mk(2'b01, 2'b11, 8'h55), 15);
      send_frame(mk(2'b01, 2'b11, 8'h55), 15, 8);
      expect_frame(mk(2'b01, 2'b11, 8'h55), 17);
      send_frame(mk(2'b01, 2'b11, 8'h55), 17, 8);
      expect_frame(32'd0, 0);
      send_frame(32'd0, 0, 8);

      // No-op commands and empty select still load the output fields.
      expect_frame(mk(2'b00, 2'b11, 8'h77), 16);
      send_frame(mk(2'b00, 2'b11, 8'h77), 16, 8);
      expect_frame(mk(2'b11, 2'b11, 8'h66), 16);
      send_frame(mk(2'b11, 2'b11, 8'h66), 16, 8);
      expect_frame(mk(2'b01, 2'b00, 8'h99), 16);
      send_frame(mk(2'b01, 2'b00, 8'h99), 16, 8);

      // Back-to-back frames with CS high for only 3 cycles.
      expect_frame(mk(2'b01, 2'b11, 8'h12), 16);
      send_frame(mk(2'b01, 2'b11, 8'h12), 16, 3);
      expect_frame(mk(2'b10, 2'b01, 8'h00), 16);
      send_frame(mk(2'b10, 2'b01, 8'h00), 16, 8);
      check("b2b_w0",   wiper0, 8'h12);
      check("b2b_shdn", shdn,   2'b01);

      // Reset in the middle of a frame: aborted silently.
      CS = 1'b0;
      repeat (2) @(negedge clk_in);
      for (int i = 0; i < 8; i++) begin
         SCK = 1'b0; MOSI = i[0];
         repeat (2) @(negedge clk_in);
         SCK = 1'b1;
         repeat (2) @(negedge clk_in);
      end
      rst_n = 1'b0; CS = 1'b1; SCK = 1'b0;
      m_w0 = 8'h80; m_w1 = 8'h80; m_shdn = 2'b00;
      m_cmd = 2'b00; m_sel = 2'b00; m_data = 8'h00;
      repeat (3) @(negedge clk_in);
      check_reset_state("mid_reset");
      rst_n = 1'b1;
      repeat (6) @(negedge clk_in);
      expect_frame(mk(2'b01, 2'b10, 8'h3C), 16);
      send_frame(mk(2'b01, 2'b10, 8'h3C), 16, 8);
      check("post_reset_w1", wiper1, 8'h3C);
      check("post_reset_w0", wiper0, 8'h80);

      repeat (20) @(negedge clk_in);
      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dfr0520_spi_rx.md
DFR0520_SPI_RX -- requirements
Module: dfr0520_spi_rx

Interface
REQ-001 Parameter FRAME_BITS, default 16: SPI bits per valid frame.
REQ-002 Parameter RESET_WIPER, default 8'h80: wiper value after reset (midscale).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on CS, SCK and MOSI.
REQ-004 clk_in  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 CS  input  1  chip select, active low, asynchronous to clk_in.
REQ-007 SCK  input  1  serial clock, idle low, asynchronous to clk_in.
REQ-008 MOSI  input  1  serial data, MSB first.
REQ-009 wiper0  output  8  current wiper code, channel 0.
REQ-010 wiper1  output  8  current wiper code, channel 1.
REQ-011 shdn  output  2  per-channel shutdown flags; bit0 = channel 0.
REQ-012 cmd_out  output  2  command field of the last valid frame.
REQ-013 sel_out  output  2  select field of the last valid frame.
REQ-014 data_out  output  8  data field of the last valid frame.
REQ-015 frame_valid  output  1  one-cycle pulse on acceptance of a valid frame.
REQ-016 frame_err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-017 CS, SCK and MOSI SHALL each pass through SYNC_STAGES flops before use; SCK frequency SHALL be at most clk_in/4.
REQ-018 A synchronized SCK low-to-high transition while synchronized CS is low SHALL shift MOSI into a 16-bit shift register, MSB first, and increment a 5-bit bit counter that saturates at 31.
REQ-019 Frame layout, bit 15 first: [15:14] don't care, [13:12] cmd, [11:10] don't care, [9:8] sel, [7:0] data.
REQ-020 FSM states: IDLE, SHIFT, CHECK.
REQ-021 IDLE -> SHIFT on synchronized CS falling edge; clear the bit counter and shift register.
REQ-022 SHIFT -> CHECK on synchronized CS rising edge; SCK edges SHALL be ignored outside SHIFT.
REQ-023 CHECK -> IDLE unconditionally after one cycle.
REQ-024 In CHECK with bit count equal to FRAME_BITS: pulse frame_valid and load cmd_out, sel_out and data_out in that cycle.
REQ-025 In CHECK with bit count not equal to FRAME_BITS (short, long or zero): pulse frame_err and change no other output.
REQ-026 Valid cmd 2'b01 (write): load data into each wiper whose sel bit is 1 and clear that channel's shdn bit.
REQ-027 Valid cmd 2'b10 (shutdown): set shdn for each channel whose sel bit is 1; wipers unchanged.
REQ-028 Valid cmd 2'b00 or 2'b11: no-op; frame_valid still pulses and the *_out fields still load.
REQ-029 sel 2'b00 SHALL affect no channel; sel 2'b11 SHALL affect both channels identically.
REQ-030 wiper0, wiper1 and shdn SHALL change only in the CHECK cycle of a valid frame.
REQ-031 Latency: frame_valid and the wiper update SHALL occur SYNC_STAGES+2 clk_in cycles after CS rises at the pin.
REQ-032 A CS glitch high for fewer than SYNC_STAGES cycles MAY be filtered; if seen, REQ-025 applies.

Reset
REQ-033 While rst_n is low: FSM = IDLE; wiper0 = wiper1 = RESET_WIPER; shdn = 2'b00; cmd_out, sel_out, data_out = 0; frame_valid = frame_err = 0; synchronizer flops for CS = 1, SCK = 0, MOSI = 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no frame_err; after release, the FSM waits in IDLE for a new CS falling edge.

Structure
REQ-035 Shared package dfr0520_pkg holds the cmd encodings (CMD_NOP = 2'b00, CMD_WRITE = 2'b01, CMD_SHDN = 2'b10) and the FSM state type, and is shared with the existing transmitter.
REQ-036 One sub-module, dfr0520_sync_edge, SHALL provide the synchronizer plus rise/fall detection; it is instantiated once each for CS and SCK and synchronizes MOSI.

Verification
REQ-037 Reset released -> wiper0 = wiper1 = 8'h80, shdn = 2'b00, no pulses.
REQ-038 Frame 16'h1_1A5 (cmd 01, sel 01, data A5) -> one frame_valid; wiper0 = 8'hA5; wiper1 unchanged; cmd_out = 01, sel_out = 01.
REQ-039 Frame 16'h2300 (cmd 10, sel 11), then frame 16'h1_2FF (cmd 01, sel 10, data FF) -> after the first, shdn = 2'b11; after the second, wiper1 = 8'hFF and shdn = 2'b01.
REQ-040 Frames of 15 bits and of 17 bits, each with cmd 01 and sel 11 -> frame_err pulses once per frame; wipers, shdn and *_out unchanged.
REQ-041 rst_n pulsed low after 8 bits, then a valid 16-bit frame with cmd 01, sel 10, data 3C -> no frame_err; wiper1 = 8'h3C.
REQ-042 Back-to-back frames with CS high for 3 clk_in cycles at SCK = clk_in/4 -> both frames are accepted in order.
